// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out handshake bundle for the Sobel window generator.
// The slave modport is the generator's view; master is the producer/consumer side.
interface sobel_window_gen_if;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_pix;
    logic       in_ready;
    logic       win_valid;
    logic       win_ready;
    logic [7:0] P1, P2, P3, P4, P5, P6, P7, P8, P9;
    logic       win_last;
    logic       frame_done;
    logic       frame_abort;

    modport slave (
        input  in_valid, in_sof, in_pix, win_ready,
        output in_ready, win_valid, P1, P2, P3, P4, P5, P6, P7, P8, P9,
               win_last, frame_done, frame_abort
    );

    modport master (
        output in_valid, in_sof, in_pix, win_ready,
        input  in_ready, win_valid, P1, P2, P3, P4, P5, P6, P7, P8, P9,
               win_last, frame_done, frame_abort
    );
endinterface

// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator: two line buffers plus a 3x3 shift register,
// one registered window per interior pixel with a single-stage output handshake.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              rst,
    sobel_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t                 state;
    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [2:0][2:0][7:0]   win;
    logic                   win_valid, win_last, frame_done, frame_abort;
    logic [7:0]             lb_top [IMG_WIDTH];
    logic [7:0]             lb_mid [IMG_WIDTH];

    logic                   in_ready, accept, take, eol, last_px, emit;
    logic [CW-1:0]          ecol;
    logic [RW-1:0]          erow;
    logic [7:0]             top_rd, mid_rd;

    // An sof pixel is always (0,0), regardless of where the counters were.
    always_comb begin
        in_ready = !win_valid || bus.win_ready;
        accept   = bus.in_valid && in_ready;
        take     = accept && (bus.in_sof || state != IDLE);
        ecol     = bus.in_sof ? '0 : col;
        erow     = bus.in_sof ? '0 : row;
        eol      = ecol == CW'(IMG_WIDTH - 1);
        last_px  = eol && erow == RW'(IMG_HEIGHT - 1);
        emit     = take && erow >= RW'(2) && ecol >= CW'(2);
        top_rd   = lb_top[ecol];
        mid_rd   = lb_mid[ecol];
    end

    // Line buffers carry no reset so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && take) begin
            lb_top[ecol] <= mid_rd;
            lb_mid[ecol] <= bus.in_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            win         <= '0;
            win_valid   <= 1'b0;
            win_last    <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= accept && bus.in_sof && state != IDLE;
            if (take) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= top_rd;
                win[1][2] <= mid_rd;
                win[2][2] <= bus.in_pix;
                if (eol) begin
                    col <= '0;
                    row <= erow + 1'b1;
                end else begin
                    col <= ecol + 1'b1;
                    row <= erow;
                end
                if (bus.in_sof) begin
                    state <= FILL;
                end else if (state == FILL && eol && erow == RW'(1)) begin
                    state <= STREAM;
                end else if (state == STREAM && last_px) begin
                    state      <= IDLE;
                    row        <= '0;
                    col        <= '0;
                    frame_done <= 1'b1;
                end
            end
            // A stall blocks accept, so emit is 0 and the output register holds.
            if (emit) begin
                win_valid <= 1'b1;
                win_last  <= last_px;
            end else if (bus.win_ready) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.win_valid   = win_valid;
    assign bus.win_last    = win_last;
    assign bus.frame_done  = frame_done;
    assign bus.frame_abort = frame_abort;
    assign bus.P1 = win[0][0];
    assign bus.P2 = win[0][1];
    assign bus.P3 = win[0][2];
    assign bus.P4 = win[1][0];
    assign bus.P5 = win[1][1];
    assign bus.P6 = win[1][2];
    assign bus.P7 = win[2][0];
    assign bus.P8 = win[2][1];
    assign bus.P9 = win[2][2];
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen at W=5, H=4 with pixel(r,c)=16r+c;
// consumed windows are checked in order against a queue of expected windows.
module tb_sobel_window_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_window_gen_if bus ();

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int ncmp = 0;
    int nerr = 0;
    int nwin, ndone, nabort, nlast;
    logic [71:0] expq[$];
    logic        lastq[$];
    bit          in_frame = 1'b0;
    int          mr, mc;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] expwin(input int r, input int c);
        logic [71:0] w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], 8'(16 * (r - 2 + i) + (c - 2 + j))};
        return w;
    endfunction

    function automatic logic [71:0] pbus();
        return {bus.P1, bus.P2, bus.P3, bus.P4, bus.P5, bus.P6, bus.P7, bus.P8, bus.P9};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Hold one pixel until accepted; reference position model advances on accept.
    task automatic send_px(input int r, input int c, input bit sof);
        bit rdy = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pix   = 8'(16 * r + c);
        for (int k = 0; k < 50 && !rdy; k++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            sync();
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        if (!rdy) begin
            chk("accept_timeout", 72'(0), 72'(1));
        end else begin
            if (sof) begin
                in_frame = 1'b1;
                mr = 0;
                mc = 0;
            end
            if (in_frame) begin
                if (mr >= 2 && mc >= 2) begin
                    expq.push_back(expwin(mr, mc));
                    lastq.push_back(mr == H - 1 && mc == W - 1);
                end
                if (mc == W - 1) begin
                    mc = 0;
                    if (mr == H - 1) in_frame = 1'b0;
                    else mr++;
                end else begin
                    mc++;
                end
            end
        end
    endtask

    task automatic frame(input int r0, input int c0, input int r1, input int c1);
        for (int r = r0; r <= r1; r++)
            for (int c = 0; c < W; c++)
                if (!(r == r0 && c < c0) && !(r == r1 && c > c1))
                    send_px(r, c, r == 0 && c == 0);
    endtask

    task automatic clr();
        nwin = 0; ndone = 0; nabort = 0; nlast = 0;
    endtask

    task automatic tally(input string tag, input int ew, input int ed, input int ea, input int el);
        repeat (3) sync();
        chk({tag, "_nwin"},  72'(nwin),   72'(ew));
        chk({tag, "_done"},  72'(ndone),  72'(ed));
        chk({tag, "_abort"}, 72'(nabort), 72'(ea));
        chk({tag, "_last"},  72'(nlast),  72'(el));
        chk({tag, "_qleft"}, 72'(expq.size()), 72'(0));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_wv"},   72'(bus.win_valid),   72'(0));
        chk({tag, "_p"},    pbus(),               72'(0));
        chk({tag, "_wl"},   72'(bus.win_last),    72'(0));
        chk({tag, "_fd"},   72'(bus.frame_done),  72'(0));
        chk({tag, "_fa"},   72'(bus.frame_abort), 72'(0));
        chk({tag, "_rdy"},  72'(bus.in_ready),    72'(1));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_done === 1'b1) begin
                ndone++;
                chk("done_with_last", 72'(bus.win_valid && bus.win_last), 72'(1));
            end
            if (bus.frame_abort === 1'b1) nabort++;
            if (bus.win_valid === 1'b1 && bus.win_ready) begin
                nwin++;
                if (bus.win_last) nlast++;
                if (expq.size() == 0) begin
                    chk("extra_window", pbus(), 72'(0));
                end else begin
                    chk("win",      pbus(),              expq.pop_front());
                    chk("win_last", 72'(bus.win_last),   72'(lastq.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_pix    = '0;
        bus.win_ready = 1'b1;
        clr();
        repeat (2) sync();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outs("rst0");
        sync();

        // Full frame: first window timing and contents, 6 windows, one done.
        clr();
        frame(0, 0, 2, 2);
        @(negedge clk);
        chk("first_wv",  72'(bus.win_valid), 72'(1));
        chk("first_win", pbus(), 72'h00_01_02_10_11_12_20_21_22);
        sync();
        frame(2, 3, 3, 4);
        tally("full", 6, 1, 0, 1);

        // Stall the second window for three cycles.
        clr();
        frame(0, 0, 2, 3);
        bus.win_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_rdy", 72'(bus.in_ready),  72'(0));
            chk("stall_wv",  72'(bus.win_valid), 72'(1));
            chk("stall_win", pbus(), 72'h01_02_03_11_12_13_21_22_23);
        end
        sync();
        bus.win_ready = 1'b1;
        frame(2, 4, 3, 4);
        tally("stall", 6, 1, 0, 1);

        // Pixels before any sof are dropped.
        clr();
        for (int k = 0; k < 8; k++) send_px(3, k % W, 1'b0);
        tally("stray", 0, 0, 0, 0);
        frame(0, 0, 3, 4);
        tally("post_stray", 6, 1, 0, 1);

        // sof at (2,3): abort, then a clean frame.
        clr();
        frame(0, 0, 2, 2);
        frame(0, 0, 3, 4);
        tally("abort", 7, 1, 1, 1);

        // Reset mid-frame at (3,1), then a full frame.
        clr();
        frame(0, 0, 3, 1);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        in_frame = 1'b0;
        expq.delete();
        lastq.delete();
        @(negedge clk);
        chk_reset_outs("rst_mid");
        sync();
        frame(0, 0, 3, 4);
        tally("after_rst", 9, 1, 0, 1);

        // Back-to-back frames.
        clr();
        frame(0, 0, 3, 4);
        frame(0, 0, 3, 4);
        tally("b2b", 12, 2, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
